// File: rtl/result_argmax_if.sv
// Handshake bundle between the output-layer datapath, the argmax collector and the host.
// Signal suffixes are from the collector's point of view (slave modport).
interface result_argmax_if #(
    parameter int DATA_W = 16
);
    logic                     start_i;
    logic                     node_valid_i;
    logic [7:0]               node_index_i;
    logic signed [DATA_W-1:0] node_value_i;
    logic                     result_ready_i;
    logic                     busy_o;
    logic                     result_valid_o;
    logic [7:0]               winner_index_o;
    logic signed [DATA_W-1:0] winner_value_o;
    logic [7:0]               nodes_seen_o;
    logic                     seq_error_o;
`ifdef RESULT_ARGMAX_MARGIN_EN
    logic [DATA_W:0]          margin_o;
`endif

    modport slave (
        input  start_i, node_valid_i, node_index_i, node_value_i, result_ready_i,
        output busy_o, result_valid_o, winner_index_o, winner_value_o, nodes_seen_o,
`ifdef RESULT_ARGMAX_MARGIN_EN
        output margin_o,
`endif
        output seq_error_o
    );

    modport master (
        output start_i, node_valid_i, node_index_i, node_value_i, result_ready_i,
        input  busy_o, result_valid_o, winner_index_o, winner_value_o, nodes_seen_o,
`ifdef RESULT_ARGMAX_MARGIN_EN
        input  margin_o,
`endif
        input  seq_error_o
    );
endinterface

// File: rtl/result_argmax.sv
// Output-layer argmax collector: tracks the running maximum over MAX_NODES activations and
// hands the winner to the host. Define RESULT_ARGMAX_MARGIN_EN to also report winner-minus-runner-up.
module result_argmax #(
    parameter int DATA_W    = 16,
    parameter int MAX_NODES = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    result_argmax_if.slave bus
);
    localparam logic signed [DATA_W-1:0] MOST_NEG   = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [7:0]               LAST_COUNT = 8'(MAX_NODES);

    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

    state_t                   state_q;
    logic                     busy_q;
    logic                     result_valid_q;
    logic                     seq_error_q;
    logic [7:0]               nodes_seen_q;
    logic [7:0]               winner_index_q;
    logic signed [DATA_W-1:0] winner_value_q;

    logic [7:0] nodes_seen_d;
    logic       beats_winner_d;
    logic       order_bad_d;

`ifdef RESULT_ARGMAX_MARGIN_EN
    logic signed [DATA_W-1:0] runner_up_q;
    logic                     beats_runner_d;
    logic [DATA_W:0]          margin_d;
`endif

    always_comb begin
        nodes_seen_d   = nodes_seen_q + 8'd1;
        beats_winner_d = bus.node_value_i > winner_value_q;
        order_bad_d    = bus.node_index_i != nodes_seen_q;
`ifdef RESULT_ARGMAX_MARGIN_EN
        beats_runner_d = bus.node_value_i > runner_up_q;
        // Winner never sits below the runner-up, so the sign-extended difference is non-negative.
        margin_d       = {winner_value_q[DATA_W-1], winner_value_q}
                       - {runner_up_q[DATA_W-1], runner_up_q};
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            seq_error_q    <= 1'b0;
            nodes_seen_q   <= 8'd0;
            winner_index_q <= 8'd0;
            winner_value_q <= '0;
`ifdef RESULT_ARGMAX_MARGIN_EN
            runner_up_q    <= '0;
`endif
        end else if (bus.start_i) begin
            // A start from any state discards whatever was in flight, including a same-cycle node.
            state_q        <= COLLECT;
            busy_q         <= 1'b1;
            result_valid_q <= 1'b0;
            seq_error_q    <= 1'b0;
            nodes_seen_q   <= 8'd0;
            winner_index_q <= 8'd0;
            winner_value_q <= MOST_NEG;
`ifdef RESULT_ARGMAX_MARGIN_EN
            runner_up_q    <= MOST_NEG;
`endif
        end else begin
            case (state_q)
                COLLECT: begin
                    if (bus.node_valid_i) begin
                        seq_error_q <= seq_error_q | order_bad_d;
                        if (beats_winner_d) begin
                            winner_value_q <= bus.node_value_i;
                            winner_index_q <= bus.node_index_i;
`ifdef RESULT_ARGMAX_MARGIN_EN
                            runner_up_q    <= winner_value_q;
`endif
                        end
`ifdef RESULT_ARGMAX_MARGIN_EN
                        else if (beats_runner_d) begin
                            runner_up_q <= bus.node_value_i;
                        end
`endif
                        nodes_seen_q <= nodes_seen_d;
                        if (nodes_seen_d == LAST_COUNT) begin
                            state_q        <= HOLD;
                            busy_q         <= 1'b0;
                            result_valid_q <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (bus.node_valid_i) begin
                        seq_error_q <= 1'b1;
                    end
                    if (bus.result_ready_i) begin
                        state_q        <= IDLE;
                        result_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy_o         = busy_q;
    assign bus.result_valid_o = result_valid_q;
    assign bus.winner_index_o = winner_index_q;
    assign bus.winner_value_o = winner_value_q;
    assign bus.nodes_seen_o   = nodes_seen_q;
    assign bus.seq_error_o    = seq_error_q;
`ifdef RESULT_ARGMAX_MARGIN_EN
    assign bus.margin_o       = margin_d;
`endif
endmodule

// File: tb/tb_result_argmax.sv
// Directed bench for result_argmax with four output nodes; margin checks build only with
// RESULT_ARGMAX_MARGIN_EN defined.
module tb_result_argmax;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [7:0]        vec_idx [4];
    logic signed [15:0] vec_val [4];

    result_argmax_if #(.DATA_W(16)) bus ();

    result_argmax #(.DATA_W(16), .MAX_NODES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic set_vals(input logic signed [15:0] a, input logic signed [15:0] b,
                            input logic signed [15:0] c, input logic signed [15:0] d);
        vec_val[0] = a; vec_val[1] = b; vec_val[2] = c; vec_val[3] = d;
        for (int i = 0; i < 4; i++) vec_idx[i] = 8'(i);
    endtask

    task automatic run_nodes(input int count);
        for (int i = 0; i < count; i++) begin
            bus.node_valid_i = 1'b1;
            bus.node_index_i = vec_idx[i];
            bus.node_value_i = vec_val[i];
            tick();
        end
        bus.node_valid_i = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        check("start_busy", {31'd0, bus.busy_o}, 32'd1);
        check("start_nodes", {24'd0, bus.nodes_seen_o}, 32'd0);
        check("start_wval", {16'd0, bus.winner_value_o}, 32'h8000);
        check("start_seq", {31'd0, bus.seq_error_o}, 32'd0);
    endtask

    task automatic check_result(input logic [7:0] idx, input logic signed [15:0] val,
                                input logic seq);
        check("res_valid", {31'd0, bus.result_valid_o}, 32'd1);
        check("res_busy", {31'd0, bus.busy_o}, 32'd0);
        check("res_index", {24'd0, bus.winner_index_o}, {24'd0, idx});
        check("res_value", {16'd0, bus.winner_value_o}, {16'd0, val});
        check("res_nodes", {24'd0, bus.nodes_seen_o}, 32'd4);
        check("res_seq", {31'd0, bus.seq_error_o}, {31'd0, seq});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.start_i = 1'b0;
        bus.node_valid_i = 1'b0;
        bus.node_index_i = 8'd0;
        bus.node_value_i = 16'sd0;
        bus.result_ready_i = 1'b1;
        tick();
        tick();
        check("rst_busy", {31'd0, bus.busy_o}, 32'd0);
        check("rst_valid", {31'd0, bus.result_valid_o}, 32'd0);
        check("rst_wval", {16'd0, bus.winner_value_o}, 32'd0);
        check("rst_nodes", {24'd0, bus.nodes_seen_o}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic argmax with ready held high in advance
        pulse_start();
        set_vals(16'sd5, -16'sd3, 16'sd12, 16'sd7);
        run_nodes(4);
        check_result(8'd2, 16'sd12, 1'b0);
        tick();
        check("ack_valid", {31'd0, bus.result_valid_o}, 32'd0);
        check("ack_busy", {31'd0, bus.busy_o}, 32'd0);

        // All most-negative values: index 0 stays winner
        pulse_start();
        set_vals(-16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768);
        run_nodes(4);
        check_result(8'd0, -16'sd32768, 1'b0);
        tick();

        // Ties keep the lowest index
        pulse_start();
        set_vals(16'sd9, 16'sd9, 16'sd1, 16'sd9);
        run_nodes(4);
        check_result(8'd0, 16'sd9, 1'b0);
        tick();

        // Hold with backpressure and a stray node
        bus.result_ready_i = 1'b0;
        pulse_start();
        set_vals(16'sd1, 16'sd50, 16'sd3, -16'sd2);
        run_nodes(4);
        check_result(8'd1, 16'sd50, 1'b0);
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                bus.node_valid_i = 1'b1;
                bus.node_index_i = 8'd0;
                bus.node_value_i = 16'sd100;
            end
            tick();
            bus.node_valid_i = 1'b0;
        end
        check_result(8'd1, 16'sd50, 1'b1);
        bus.result_ready_i = 1'b1;
        tick();
        check("hold_ack_valid", {31'd0, bus.result_valid_o}, 32'd0);
        check("hold_ack_seq", {31'd0, bus.seq_error_o}, 32'd1);

        // Out-of-order indices
        pulse_start();
        set_vals(16'sd4, -16'sd1, 16'sd6, 16'sd20);
        vec_idx[1] = 8'd2;
        vec_idx[2] = 8'd1;
        run_nodes(4);
        check_result(8'd3, 16'sd20, 1'b1);
        tick();

        // Restart mid-run, with a node in the start cycle
        pulse_start();
        set_vals(16'sd100, 16'sd200, 16'sd0, 16'sd0);
        run_nodes(2);
        check("mid_nodes", {24'd0, bus.nodes_seen_o}, 32'd2);
        bus.start_i = 1'b1;
        bus.node_valid_i = 1'b1;
        bus.node_index_i = 8'd2;
        bus.node_value_i = 16'sd999;
        tick();
        bus.start_i = 1'b0;
        bus.node_valid_i = 1'b0;
        check("restart_busy", {31'd0, bus.busy_o}, 32'd1);
        check("restart_nodes", {24'd0, bus.nodes_seen_o}, 32'd0);
        check("restart_wval", {16'd0, bus.winner_value_o}, 32'h8000);
        set_vals(16'sd1, 16'sd2, 16'sd3, 16'sd4);
        run_nodes(4);
        check_result(8'd3, 16'sd4, 1'b0);
        tick();

`ifdef RESULT_ARGMAX_MARGIN_EN
        pulse_start();
        set_vals(16'sd10, 16'sd30, 16'sd25, -16'sd5);
        run_nodes(4);
        check_result(8'd1, 16'sd30, 1'b0);
        check("margin_5", {15'd0, bus.margin_o}, 32'd5);
        tick();

        pulse_start();
        set_vals(16'sd8, 16'sd8, -16'sd1, -16'sd2);
        run_nodes(4);
        check_result(8'd0, 16'sd8, 1'b0);
        check("margin_tie", {15'd0, bus.margin_o}, 32'd0);
        tick();
`endif

        // Asynchronous reset in the middle of collection
        pulse_start();
        set_vals(16'sd7, 16'sd8, 16'sd0, 16'sd0);
        run_nodes(2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, bus.busy_o}, 32'd0);
        check("arst_nodes", {24'd0, bus.nodes_seen_o}, 32'd0);
        check("arst_wval", {16'd0, bus.winner_value_o}, 32'd0);
        check("arst_widx", {24'd0, bus.winner_index_o}, 32'd0);
`ifdef RESULT_ARGMAX_MARGIN_EN
        check("arst_margin", {15'd0, bus.margin_o}, 32'd0);
`endif
        tick();
        rst_n = 1'b1;
        tick();
        check("arst_idle", {31'd0, bus.busy_o}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/result_argmax.md
# result_argmax

Output-layer result collector. Sits directly downstream of the neural-network control unit and datapath. While the output layer runs, it accepts one signed activation per output node and tracks the running maximum. After the last node it presents the winning class index and value to the host through a valid/ready handshake, holding them until consumed.

## Interface
- DATA_W, 16, width of signed node activation
- MAX_NODES, 10, number of output-layer nodes expected per inference (1..255)
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse: clear and begin collecting a new inference
- node_valid  in  1  node_value/node_index valid this cycle
- node_index  in  8  output node number (driven from outputNodeNumber)
- node_value  in  DATA_W  signed two's-complement activation
- result_ready  in  1  consumer accepts result
- busy  out  1  high in COLLECT
- result_valid  out  1  winner available
- winner_index  out  8  index of maximum activation
- winner_value  out  DATA_W  maximum activation
- nodes_seen  out  8  count of nodes accepted this inference
- seq_error  out  1  sticky: out-of-order index or count mismatch

## Operation
- States: IDLE, COLLECT, HOLD. Reset → IDLE; all outputs 0.
- IDLE: start → COLLECT. Clear nodes_seen and seq_error. Load winner_value with the most negative value (0x8000 for 16 bits) and winner_index with 0. node_valid is ignored.
- COLLECT: each node_valid is accepted. The node must have node_index == nodes_seen; otherwise set seq_error, but still compare and count.
  - Replace the winner only if node_value > winner_value (strictly greater, signed). On a tie the lower index is kept.
  - nodes_seen increments on each accept.
  - When the accepted node makes nodes_seen == MAX_NODES → HOLD.
- HOLD: result_valid = 1. winner_index, winner_value and nodes_seen are frozen.
  - result_valid && result_ready → IDLE; result_valid drops the next cycle.
  - node_valid in HOLD is ignored and sets seq_error.
- start in COLLECT or HOLD restarts: clear and re-enter COLLECT. Any pending result is discarded. start has priority over node_valid in the same cycle, and that node is not accepted.
- seq_error is sticky until the next start or reset.

## Timing
- Single cycle per node. Compare and update are registered at the accepting edge; outputs reflect the node one cycle later.
- result_valid rises 1 cycle after the edge that accepts node MAX_NODES-1.
- result_ready may be held high in advance; the handshake completes on the first cycle result_valid is high.
- Back-to-back node_valid every cycle is supported. There is no backpressure on node input.
- Asynchronous reset mid-inference returns to IDLE immediately; outputs go to 0.

## Configuration
- RESULT_ARGMAX_MARGIN_EN defined: additionally track the runner-up and add output margin (DATA_W+1 bits, unsigned). margin = winner_value − runner_up_value, valid with result_valid.
  - The runner-up resets with the winner to the most negative value.
  - On replacement, the old winner becomes the runner-up. Otherwise, if node_value > runner_up, the runner-up takes node_value.
  - A tie with the winner updates the runner-up, giving margin 0.
- Not defined: no runner-up logic, no margin port.

## Test plan
- MAX_NODES=4, values {5, −3, 12, 7} at indices 0..3 with result_ready=1 → result_valid 1 cycle after last accept, winner_index=2, winner_value=12, nodes_seen=4, seq_error=0, back to IDLE next cycle.
- All values −32768 → winner_index=0. Ties {9, 9, 1, 9} → winner_index=0 (lowest index wins).
- result_ready held 0 for 5 cycles in HOLD, with node_valid pulsed once → outputs frozen, seq_error=1, result consumed when ready rises.
- Indices {0, 2, 1, 3} → seq_error=1, correct argmax still reported.
- start asserted after 2 nodes, then a fresh 4-node run {1, 2, 3, 4} → winner_index=3, nodes_seen=4. Start plus node_valid in the same cycle → that node is not counted.
- With RESULT_ARGMAX_MARGIN_EN: {10, 30, 25, −5} → winner 30, margin=5. {8, 8} (MAX_NODES=2) → margin=0. Reset asserted mid-COLLECT → all outputs 0, state IDLE.
